// File: rtl/cpu_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_div_pkg
// Description : Shared state encoding and sizing helpers for the divider.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef logic [2:0] div_state_t;

    localparam div_state_t ST_IDLE = 3'd0;
    localparam div_state_t ST_CALC = 3'd1;
    localparam div_state_t ST_FIX  = 3'd2;
    localparam div_state_t ST_ZERO = 3'd3;
    localparam div_state_t ST_DONE = 3'd4;

    function automatic int div_cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int DIV_CNT_W = div_cnt_width(DIV_WIDTH);

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring shift-subtract iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_dividend_bit,
    input  logic [WIDTH-1:0] i_divisor_mag,
    output logic [WIDTH:0]   o_rem,
    output logic             o_quo_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // The partial remainder is always below the divisor, so the extra bit
    // keeps the shifted value and the compare free of overflow.
    assign w_shift   = (i_rem << 1) | {{WIDTH{1'b0}}, i_dividend_bit};
    assign w_ge      = (w_shift >= {1'b0, i_divisor_mag});
    assign w_diff    = w_shift - {1'b0, i_divisor_mag};
    assign o_rem     = w_ge ? w_diff : w_shift;
    assign o_quo_bit = w_ge;

endmodule
`default_nettype wire

// File: rtl/alu_div.sv
`default_nettype none
// ============================================================================
// Module      : alu_div
// Description : Iterative signed/unsigned restoring divider, one bit/clock.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_div
    import cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int             CNT_W    = div_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    div_state_t       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr_mag;
    logic [WIDTH-1:0] r_dvd_orig;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_zero;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_step_rem;
    logic             w_step_q;

    assign w_dvd_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign w_dvs_mag = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem          (r_rem),
        .i_dividend_bit (r_quo[WIDTH-1]),
        .i_divisor_mag  (r_dvsr_mag),
        .o_rem          (w_step_rem),
        .o_quo_bit      (w_step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (divisor == '0) ? ST_ZERO : ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_FIX;
                end
            end
            ST_FIX:  w_state_next = ST_DONE;
            ST_ZERO: w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The quotient register doubles as the dividend shifter: its MSB feeds
    // the step while new quotient bits enter at the bottom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvsr_mag  <= '0;
            r_dvd_orig  <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt      <= CNT_INIT;
                        r_rem      <= '0;
                        r_quo      <= w_dvd_mag;
                        r_dvsr_mag <= w_dvs_mag;
                        r_dvd_orig <= dividend;
                        r_neg_q    <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_r    <= is_signed & dividend[WIDTH-1];
                        r_div_zero <= 1'b0;
                    end
                end
                ST_CALC: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[WIDTH-2:0], w_step_q};
                    r_cnt <= r_cnt - 1'b1;
                end
                ST_FIX: begin
                    r_quotient  <= r_neg_q ? -r_quo : r_quo;
                    r_remainder <= r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
                end
                ST_ZERO: begin
                    r_quotient  <= '1;
                    r_remainder <= r_dvd_orig;
                    r_div_zero  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_alu_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_div
// Description : Self-checking bench for alu_div against a cycle-count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_div;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    alu_div #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain integer arithmetic (C-style truncation).
    function automatic void ref_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dz);
        longint sa;
        longint sb;
        if (b == '0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
            return;
        end
        dz = 1'b0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = W'(sa / sb);
        r = W'(sa % sb);
    endfunction

    // Model: cycles remaining until idle; results appear in the done cycle.
    int           m_cnt = 0;
    logic [W-1:0] m_q   = '0;
    logic [W-1:0] m_r   = '0;
    logic         m_dz  = 1'b0;
    logic [W-1:0] p_q   = '0;
    logic [W-1:0] p_r   = '0;
    logic         p_dz  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0;
            m_q   = '0;
            m_r   = '0;
            m_dz  = 1'b0;
        end else if (m_cnt == 0) begin
            if (start) begin
                ref_div(is_signed, dividend, divisor, p_q, p_r, p_dz);
                m_dz  = 1'b0;
                m_cnt = (divisor == '0) ? 2 : W + 2;
            end
        end else begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 1) begin
                m_q  = p_q;
                m_r  = p_r;
                m_dz = p_dz;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_cnt != 0));
            chk("done", 32'(done), 32'(m_cnt == 1));
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("div_zero", 32'(div_zero), 32'(m_dz));
        end
    end

    // Called at a negedge; returns at a negedge with the divider idle.
    task automatic run(input string nm, input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int lat, input logic [W-1:0] eq, input logic [W-1:0] er, input bit edz,
                       input int pulse_at, input logic [W-1:0] pa, input logic [W-1:0] pb);
        int first_done;
        int ndone;
        first_done = 0;
        ndone      = 0;
        start      = 1'b1;
        is_signed  = sgn;
        dividend   = a;
        divisor    = b;
        for (int n = 1; n <= lat + 4; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                chk({nm, "_dz_cleared"}, 32'(div_zero), 32'd0);
            end
            if (n == pulse_at) begin
                start    = 1'b1;
                dividend = pa;
                divisor  = pb;
            end else if (n == pulse_at + 1) begin
                start = 1'b0;
            end
            if (done) begin
                if (first_done == 0) first_done = n;
                ndone++;
            end
        end
        chk({nm, "_latency"}, 32'(first_done), 32'(lat));
        chk({nm, "_done_pulses"}, 32'(ndone), 32'd1);
        chk({nm, "_q"}, quotient, eq);
        chk({nm, "_r"}, remainder, er);
        chk({nm, "_dz"}, 32'(div_zero), 32'(edz));
        chk({nm, "_model_q"}, m_q, eq);
        chk({nm, "_model_r"}, m_r, er);
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return W'($urandom_range(0, 15));
            5:       return -W'($urandom_range(1, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        run("u100_7", 1'b0, 32'd100, 32'd7, W + 2, 32'd14, 32'd2, 1'b0, 0, '0, '0);
        run("s_m7_2", 1'b1, -32'sd7, 32'd2, W + 2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0, '0, '0);
        run("s7_m2", 1'b1, 32'd7, -32'sd2, W + 2, 32'hFFFF_FFFD, 32'd1, 1'b0, 0, '0, '0);
        run("dz", 1'b0, 32'h1234_5678, 32'd0, 2, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 0, '0, '0);
        run("after_dz", 1'b0, 32'd20, 32'd4, W + 2, 32'd5, 32'd0, 1'b0, 0, '0, '0);
        run("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, W + 2, 32'h8000_0000, 32'd0, 1'b0, 0, '0, '0);
        run("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, W + 2, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, '0, '0);
        run("u_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, W + 2, 32'd1, 32'd1, 1'b0, 0, '0, '0);
        run("busy_ign", 1'b0, 32'd50, 32'd5, W + 2, 32'd10, 32'd0, 1'b0, 5, 32'd9, 32'd3);

        // Reset in the middle of an operation.
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_q", quotient, 32'd0);
        chk("midrst_r", remainder, 32'd0);
        chk("midrst_dz", 32'(div_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("post_rst", 1'b0, 32'd9, 32'd4, W + 2, 32'd2, 32'd1, 1'b0, 0, '0, '0);

        // Random traffic, including start held during busy and done cycles.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 3) == 0);
            is_signed = 1'($urandom_range(0, 1));
            dividend  = rnd_op();
            divisor   = rnd_op();
        end
        start = 1'b0;
        repeat (W + 6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_div.md
Name: alu_div

Overview:
- Iterative sequential integer divider for the CPU execute stage.
- Complements the combinational ALU multiplier: it performs the inverse operation, splitting a dividend into quotient and remainder.
- Uses the restoring shift-subtract method, one quotient bit per clock.
- Supports signed and unsigned operands and handles divide-by-zero explicitly.
- Uses a start/busy/done handshake so the pipeline control can stall while the divider works.

Parameters:
- WIDTH, 32, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a division; sampled only while idle.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- dividend  input  WIDTH  numerator; sampled with start.
- divisor  input  WIDTH  denominator; sampled with start.
- busy  output  1  high from the cycle after start is accepted until the cycle done is high.
- done  output  1  one-cycle pulse; results are valid in this cycle.
- quotient  output  WIDTH  result quotient; held until the next accepted start.
- remainder  output  WIDTH  result remainder; held until the next accepted start.
- div_zero  output  1  set with done when divisor == 0; held with the results.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE.
  - busy, done, div_zero = 0; quotient, remainder = 0.
  - Any in-flight operation is discarded.
  - After reset release, the first start is accepted normally.
- States:
  - IDLE: start=1 latches operands and moves to CALC, or to ZERO if divisor==0. start=0 stays in IDLE.
  - CALC: counter runs WIDTH-1 down to 0. Each cycle, {rem,quo} shifts left 1. If the shifted rem >= |divisor|, then rem -= |divisor| and quo[0]=1. After the count-0 cycle, go to FIX.
  - FIX: applies sign correction (signed mode only), writes the outputs, then goes to DONE.
  - ZERO: quotient = all ones, remainder = original dividend, div_zero = 1, then goes to DONE.
  - DONE: done=1 for exactly this cycle, then IDLE. No start is accepted in this cycle.
- Latency (start high at edge T):
  - Normal division: done high in cycle T+WIDTH+2, i.e. 34 cycles for WIDTH=32.
  - Divide-by-zero: done high in cycle T+2.
- busy:
  - High from T+1 through the done cycle inclusive.
  - start while busy is ignored; operands are not re-sampled.
- Signed mode:
  - Both operands are converted to magnitudes before CALC.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend, giving truncation toward zero.
- Overflow, most-negative / -1: quotient = most-negative value, remainder = 0, div_zero = 0. This falls out of the WIDTH-bit wrap; no extra flag.
- Unsigned mode: no sign handling; MSB is a magnitude bit.
- div_zero is cleared when the next start is accepted.
- Internal partial remainder is WIDTH+1 bits so the compare never overflows.

Decomposition:
- Shared package cpu_div_pkg holds:
  - state encoding constants: IDLE, CALC, FIX, ZERO, DONE (3-bit);
  - DIV_WIDTH default = 32;
  - counter width = clog2(WIDTH).
- One natural sub-module, div_step:
  - combinational single restoring iteration;
  - inputs: partial remainder, next dividend bit, |divisor|;
  - outputs: new partial remainder, quotient bit.
- Instantiated once and used every CALC cycle.

Test Plan:
- Unsigned 100 / 7, is_signed=0 -> done at T+34 with quotient=14, remainder=2, div_zero=0. busy high T+1..T+34.
- Signed -7 / 2 -> quotient=-3 (32'hFFFF_FFFD), remainder=-1 (32'hFFFF_FFFF). Signed 7 / -2 -> quotient=-3, remainder=1.
- Divide by zero, dividend=32'h1234_5678, divisor=0 -> done at T+2 with quotient=32'hFFFF_FFFF, remainder=32'h1234_5678, div_zero=1. The next normal start clears div_zero.
- Signed 32'h8000_0000 / 32'hFFFF_FFFF -> quotient=32'h8000_0000, remainder=0. Unsigned 32'hFFFF_FFFF / 1 -> quotient=32'hFFFF_FFFF, remainder=0.
- Start 50 / 5, then pulse start again at T+5 with 9 / 3 -> second request ignored; done at T+34 with quotient=10, remainder=0; only one done pulse.
- Start 1000 / 3, assert rst_n=0 at T+10 -> outputs zero immediately. After release, 9 / 4 -> quotient=2, remainder=1 at the normal latency.
